// File: rtl/mmcme2_drp_div_reconfig_if.sv
// DRP bus between the divider reprogrammer (master) and the MMCME2_ADV
// dynamic reconfiguration port (slave).
//   drp_addr : DADDR, 7 bits
//   drp_en   : DEN, single-cycle strobe
//   drp_we   : DWE, qualifies drp_en as a write
//   drp_di   : DI, write data
//   drp_do   : DO, read data from the MMCM
//   drp_rdy  : DRDY, transaction complete
interface mmcme2_drp_div_reconfig_if;
  logic [6:0]  drp_addr;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_rdy;

  modport master (output drp_addr, drp_en, drp_we, drp_di, input drp_do, drp_rdy);
  modport slave  (input drp_addr, drp_en, drp_we, drp_di, output drp_do, drp_rdy);
endinterface

// File: rtl/mmcme2_drp_div_reconfig.sv
// Runtime reprogrammer for the CLKOUT0..N-1 dividers of one MMCME2_ADV.
// A new divide set is validated, the MMCM is held in reset, each output's
// CLKOUT reg1/reg2 is read-modify-written over DRP, then reset is released
// and lock is awaited with a timeout. The VCO settings are never touched.
// Ports:
//   clk_i, reset_n_i : DCLK and async active-low reset
//   cfg_v_i, cfg_div_i, cfg_ready_o : divide-set handshake (7 bits/output)
//   done_o   : one-cycle pulse at the end of a requested sequence
//   err_o    : sticky error (zero divide, DRP timeout, lock timeout)
//   locked_o : synchronised MMCM lock, forced low while reprogramming
//   mmcm_rst_o, mmcm_locked_i : MMCM RST / LOCKED
//   drp      : DRP master port
module mmcme2_drp_div_reconfig #(
  parameter int num_out_p      = 4,
  parameter int drp_timeout_p  = 64,
  parameter int lock_timeout_p = 65536
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   cfg_v_i,
  input  logic [7*num_out_p-1:0] cfg_div_i,
  output logic                   cfg_ready_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   locked_o,
  output logic                   mmcm_rst_o,
  input  logic                   mmcm_locked_i,
  mmcme2_drp_div_reconfig_if.master drp
);
  localparam int NREG  = 2 * num_out_p;
  localparam int OW    = (num_out_p > 1) ? $clog2(num_out_p) : 1;
  localparam int IDX_W = OW + 1;
  localparam int DCW   = $clog2(drp_timeout_p + 1);
  localparam int LCW   = $clog2(lock_timeout_p + 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT
  } state_t;

  state_t                        state_q, state_d;
  logic [num_out_p-1:0][6:0]     div_q, div_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [7:0]                    old_hi_q, old_hi_d;   // old[15:8], kept in reg2
  logic                          old12_q, old12_d;     // old[12], reserved bit of reg1
  logic [DCW-1:0]                dcnt_q, dcnt_d;
  logic [LCW-1:0]                lcnt_q, lcnt_d;
  logic                          err_q, err_d;
  logic                          done_q, done_d;
  logic                          locked_q, locked_d;
  logic                          mrst_q, mrst_d;
  logic                          seq_q, seq_d;         // a requested sequence is in flight
  logic                          en_q, en_d;
  logic                          we_q, we_d;
  logic [6:0]                    addr_q, addr_d;
  logic [15:0]                   di_q, di_d;
  logic                          lock_s1_q, lock_s_q;

  // Divide-zero detect across all lanes of the latched set.
  logic [num_out_p-1:0] zero;
  for (genvar g = 0; g < num_out_p; g++) begin : g_zero
    assign zero[g] = (div_q[g] == 7'd0);
  end

  // Current register: idx[0] selects reg1/reg2, upper bits select the output.
  logic [OW-1:0] out_sel;
  logic [6:0]    cur_div, cur_addr;
  logic [5:0]    hi, lo;
  logic          nocnt;
  logic [15:0]   wr1, wr2;

  assign out_sel = idx_q[IDX_W-1:1];
  assign cur_div = div_q[out_sel];

  always_comb begin
    case (3'(out_sel))
      3'd0:    cur_addr = 7'h08;
      3'd1:    cur_addr = 7'h0A;
      3'd2:    cur_addr = 7'h0C;
      3'd3:    cur_addr = 7'h0E;
      3'd4:    cur_addr = 7'h10;
      3'd5:    cur_addr = 7'h06;   // CLKOUT5 lives below CLKOUT0 in the map
      3'd6:    cur_addr = 7'h12;
      default: cur_addr = 7'h08;
    endcase
    cur_addr = cur_addr | {6'd0, idx_q[0]};
  end

  // High/low counts; divide-by-1 bypasses the counter but keeps 1/1.
  always_comb begin
    hi    = cur_div[6:1];
    lo    = 6'(cur_div - {1'b0, hi});
    nocnt = (cur_div == 7'd1);
    if (nocnt) begin
      hi = 6'd1;
      lo = 6'd1;
    end
  end

  assign wr1 = {3'b000, old12_q, hi, lo};
  assign wr2 = {old_hi_q, cur_div[0], nocnt, 6'b0};

  logic unused_do;
  assign unused_do = ^{drp.drp_do[11:9], drp.drp_do[7:0]};

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    old_hi_d = old_hi_q;
    old12_d  = old12_q;
    dcnt_d   = dcnt_q;
    lcnt_d   = lcnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    locked_d = locked_q;
    mrst_d   = mrst_q;
    seq_d    = seq_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    di_d     = di_q;
    case (state_q)
      IDLE: begin
        locked_d = lock_s_q;
        if (cfg_v_i) begin
          div_d   = cfg_div_i;
          err_d   = 1'b0;
          seq_d   = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        locked_d = lock_s_q;
        if (|zero) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          seq_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = RST;
        end
      end
      RST: begin
        mrst_d   = 1'b1;
        locked_d = 1'b0;
        idx_d    = '0;
        state_d  = RD;
      end
      RD: begin
        en_d    = 1'b1;
        addr_d  = cur_addr;
        dcnt_d  = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (drp.drp_rdy) begin
          old_hi_d = drp.drp_do[15:8];
          old12_d  = drp.drp_do[12];
          state_d  = WR;
        end else if (dcnt_q == DCW'(drp_timeout_p - 1)) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      WR: begin
        en_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = cur_addr;
        di_d    = idx_q[0] ? wr2 : wr1;
        dcnt_d  = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp.drp_rdy) begin
          if (idx_q == IDX_W'(NREG - 1)) begin
            state_d = RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end else if (dcnt_q == DCW'(drp_timeout_p - 1)) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      RELEASE: begin
        mrst_d   = 1'b0;
        lcnt_d   = '0;
        locked_d = 1'b0;
        state_d  = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        locked_d = 1'b0;
        if (lock_s_q) begin
          locked_d = 1'b1;
          done_d   = seq_q;
          seq_d    = 1'b0;
          state_d  = IDLE;
        end else if (lcnt_q == LCW'(lock_timeout_p - 1)) begin
          err_d    = 1'b1;
          done_d   = seq_q;
          seq_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = RELEASE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= RELEASE;   // power-up behaves as a lock wait
      div_q     <= '0;
      idx_q     <= '0;
      old_hi_q  <= '0;
      old12_q   <= 1'b0;
      dcnt_q    <= '0;
      lcnt_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      locked_q  <= 1'b0;
      mrst_q    <= 1'b1;
      seq_q     <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      di_q      <= '0;
      lock_s1_q <= 1'b0;
      lock_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      old_hi_q  <= old_hi_d;
      old12_q   <= old12_d;
      dcnt_q    <= dcnt_d;
      lcnt_q    <= lcnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      locked_q  <= locked_d;
      mrst_q    <= mrst_d;
      seq_q     <= seq_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      lock_s1_q <= mmcm_locked_i;
      lock_s_q  <= lock_s1_q;
    end
  end

  assign cfg_ready_o  = (state_q == IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign locked_o     = locked_q;
  assign mmcm_rst_o   = mrst_q;
  assign drp.drp_en   = en_q;
  assign drp.drp_we   = we_q;
  assign drp.drp_addr = addr_q;
  assign drp.drp_di   = di_q;
endmodule

// File: tb/tb_mmcme2_drp_div_reconfig.sv
// Bench for mmcme2_drp_div_reconfig: behavioural MMCM lock model, DRP slave
// with a register file and random latency, and an arithmetic reference for
// the expected DRP transaction list of each divide set.
module tb_mmcme2_drp_div_reconfig;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_v = 1'b0;
  logic [7*N-1:0] cfg_div = '0;
  logic cfg_ready, done, err, locked, mmcm_rst;
  logic mmcm_locked = 1'b0;

  mmcme2_drp_div_reconfig_if drp_if();

  mmcme2_drp_div_reconfig #(.num_out_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cfg_v_i(cfg_v), .cfg_div_i(cfg_div),
    .cfg_ready_o(cfg_ready), .done_o(done), .err_o(err), .locked_o(locked),
    .mmcm_rst_o(mmcm_rst), .mmcm_locked_i(mmcm_locked), .drp(drp_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lock model: LOCKED rises 100 cycles after RST is released.
  int lock_cnt = 0;
  bit lock_hold_low = 1'b0;
  always @(posedge clk) begin
    if (mmcm_rst || lock_hold_low) begin
      lock_cnt    <= 0;
      mmcm_locked <= 1'b0;
    end else if (lock_cnt == 99) mmcm_locked <= 1'b1;
    else lock_cnt <= lock_cnt + 1;
  end

  // DRP slave model.
  typedef struct { logic [6:0] addr; logic we; logic [15:0] di; int cyc; } tx_t;
  tx_t log_q[$];
  logic [15:0] mem [128];
  int fill_gen = 0, fill_seen = 0;
  bit fill_rand = 1'b0;
  logic [15:0] fill_val = '0;
  int rd_total = 0;
  int drop_rd = 0;
  int pend = 0;

  always @(posedge clk) begin
    drp_if.drp_rdy <= 1'b0;
    if (pend == 1) drp_if.drp_rdy <= 1'b1;
    if (pend != 0) pend <= pend - 1;
    if (fill_gen != fill_seen) begin
      for (int a = 0; a < 128; a++) mem[a] <= fill_rand ? 16'($urandom) : fill_val;
      fill_seen <= fill_gen;
    end
    if (drp_if.drp_en) begin
      log_q.push_back(tx_t'{addr: drp_if.drp_addr, we: drp_if.drp_we, di: drp_if.drp_di, cyc: cyc});
      if (drp_if.drp_we) mem[drp_if.drp_addr] <= drp_if.drp_di;
      else begin
        drp_if.drp_do <= mem[drp_if.drp_addr];
        rd_total      <= rd_total + 1;
      end
      if (drp_if.drp_we || drop_rd != rd_total + 1) pend <= $urandom_range(4, 1);
    end
  end

  // Reference model of the register map and divide encoding.
  function automatic int addr1(input int k);
    int tbl[7] = '{8, 10, 12, 14, 16, 6, 18};
    return tbl[k];
  endfunction

  function automatic logic [15:0] m_reg1(input int d, input logic [15:0] old);
    int hi, lo;
    hi = d / 2;
    lo = d - hi;
    if (d == 1) begin hi = 1; lo = 1; end
    return 16'(int'(old[12]) * 4096 + (hi % 64) * 64 + (lo % 64));
  endfunction

  function automatic logic [15:0] m_reg2(input int d, input logic [15:0] old);
    return 16'((int'(old) / 256) * 256 + (d % 2) * 128 + ((d == 1) ? 64 : 0));
  endfunction

  function automatic logic [7*N-1:0] pack(input int dv[N]);
    logic [7*N-1:0] w = '0;
    for (int k = 0; k < N; k++) w[7*k +: 7] = 7'(dv[k]);
    return w;
  endfunction

  task automatic set_mem(input bit rnd, input logic [15:0] v);
    fill_rand = rnd;
    fill_val  = v;
    fill_gen  = fill_gen + 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic launch(input logic [7*N-1:0] w);
    int c = 0;
    @(negedge clk);
    while (!cfg_ready && c < 1000) begin @(negedge clk); c++; end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL launch_ready: cfg_ready_o=%b, required 1", cfg_ready);
    end
    cfg_v   = 1'b1;
    cfg_div = w;
    @(negedge clk);
    cfg_v   = 1'b0;
  endtask

  // Full reprogramming sequence checked against the reference transaction list.
  task automatic run_seq(input int dv[N], input bit poke, output int base);
    logic [15:0] o1[N], o2[N];
    logic [6:0] ea; logic ew; logic [15:0] ed, od;
    int c; bit got_done, lock_bad;
    for (int k = 0; k < N; k++) begin
      o1[k] = mem[addr1(k)];
      o2[k] = mem[addr1(k) + 1];
    end
    base = log_q.size();
    launch(pack(dv));
    got_done = 0; lock_bad = 0; c = 0;
    while (!got_done && c < 3000) begin
      @(negedge clk); c++;
      if (done) got_done = 1;
      if (mmcm_rst && locked) lock_bad = 1;
      if (poke && c == 4) begin cfg_v = 1'b1; cfg_div = ~pack(dv); end
      if (c == 7) cfg_v = 1'b0;
    end
    checks++;
    if (!got_done) begin errors++; $display("FAIL seq_done: done_o not seen after %0d cycles, required pulse", c); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL seq_err: err_o=%b, required 0", err); end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL seq_locked: locked_o=%b, required 1", locked); end
    checks++;
    if (lock_bad) begin errors++; $display("FAIL seq_locked_in_rst: locked_o=1 while mmcm_rst_o=1, required 0"); end
    checks++;
    if (log_q.size() - base != 4 * N) begin
      errors++;
      $display("FAIL seq_tx_count: %0d DRP transactions, required %0d", log_q.size() - base, 4 * N);
    end else begin
      for (int i = 0; i < 4 * N; i++) begin
        int k = i / 4;
        int s = i % 4;
        ea = 7'((s < 2) ? addr1(k) : addr1(k) + 1);
        ew = (s == 1 || s == 3);
        ed = (s == 1) ? m_reg1(dv[k], o1[k]) : (s == 3) ? m_reg2(dv[k], o2[k]) : 16'h0;
        od = ew ? log_q[base + i].di : 16'h0;
        checks++;
        if ({log_q[base + i].addr, log_q[base + i].we, od} !== {ea, ew, ed}) begin
          errors++;
          $display("FAIL seq_tx%0d: addr=%h we=%b di=%h, required addr=%h we=%b di=%h",
                   i, log_q[base + i].addr, log_q[base + i].we, od, ea, ew, ed);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({mmcm_rst, cfg_ready, done, err, locked} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_status: rst/ready/done/err/locked=%b, required 10000", {mmcm_rst, cfg_ready, done, err, locked});
    end
    checks++;
    if ({drp_if.drp_en, drp_if.drp_we, drp_if.drp_addr, drp_if.drp_di} !== 25'd0) begin
      errors++;
      $display("FAIL reset_drp: en=%b we=%b addr=%h di=%h, required all 0",
               drp_if.drp_en, drp_if.drp_we, drp_if.drp_addr, drp_if.drp_di);
    end
  endtask

  task automatic test_powerup();
    int c = 0;
    bit saw_done = 0;
    reset_n = 1'b1;
    while (mmcm_rst && c < 20) begin @(negedge clk); c++; end
    checks++;
    if (mmcm_rst !== 1'b0) begin errors++; $display("FAIL pwr_rst_release: mmcm_rst_o=%b, required 0", mmcm_rst); end
    c = 0;
    while (!locked && c < 300) begin
      @(negedge clk); c++;
      if (done) saw_done = 1;
    end
    checks++;
    if (c < 100 || c > 106) begin errors++; $display("FAIL pwr_lock_time: locked_o after %0d cycles, required 100..106", c); end
    checks++;
    if (saw_done) begin errors++; $display("FAIL pwr_done: done_o pulsed, required none"); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL pwr_ready: cfg_ready_o=%b, required 1", cfg_ready); end
  endtask

  task automatic test_directed();
    int dv[N] = '{40, 4, 2, 2};
    int b;
    set_mem(1'b0, 16'h0000);
    run_seq(dv, 1'b0, b);
    checks++;
    if (log_q[b + 1].di !== 16'h0514) begin errors++; $display("FAIL dir_d0_reg1: %h, required 0514", log_q[b + 1].di); end
    checks++;
    if (log_q[b + 15].di !== 16'h0000) begin errors++; $display("FAIL dir_d3_reg2: %h, required 0000", log_q[b + 15].di); end
  endtask

  task automatic test_d1_d7();
    int dv[N] = '{1, 7, 3, 100};
    int b;
    logic [15:0] w;
    set_mem(1'b0, 16'hFFFF);
    run_seq(dv, 1'b0, b);
    checks++;
    if (log_q[b + 1].di !== 16'h1041) begin errors++; $display("FAIL d1_reg1: %h, required 1041", log_q[b + 1].di); end
    w = log_q[b + 3].di;
    checks++;
    if (w[6] !== 1'b1) begin errors++; $display("FAIL d1_nocnt: reg2=%h nocnt=%b, required 1", w, w[6]); end
    checks++;
    if (log_q[b + 5].di !== 16'h10C4) begin errors++; $display("FAIL d7_reg1: %h, required 10C4", log_q[b + 5].di); end
    checks++;
    if (log_q[b + 7].di !== 16'hFF80) begin errors++; $display("FAIL d7_reg2: %h, required FF80", log_q[b + 7].di); end
  endtask

  task automatic test_div_zero();
    int dv[N] = '{3, 9, 0, 5};
    int base, c;
    bit got_done = 0, rst_seen = 0;
    base = log_q.size();
    launch(pack(dv));
    for (c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
      if (mmcm_rst) rst_seen = 1;
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL zero_err: err_o=%b, required 1", err); end
    checks++;
    if (!got_done) begin errors++; $display("FAIL zero_done: no done_o pulse, required pulse"); end
    checks++;
    if (log_q.size() != base) begin errors++; $display("FAIL zero_drp: %0d transactions, required 0", log_q.size() - base); end
    checks++;
    if (rst_seen) begin errors++; $display("FAIL zero_rst: mmcm_rst_o asserted, required 0"); end
    checks++;
    if ({cfg_ready, locked} !== 2'b11) begin errors++; $display("FAIL zero_idle: ready/locked=%b, required 11", {cfg_ready, locked}); end
  endtask

  task automatic test_random();
    int dv[N];
    int b;
    for (int it = 0; it < 4; it++) begin
      set_mem(1'b1, 16'h0);
      for (int k = 0; k < N; k++) dv[k] = $urandom_range(127, 1);
      run_seq(dv, it[0], b);
      repeat (5) @(negedge clk);
      checks++;
      if (log_q.size() != b + 4 * N || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_quiet%0d: tx=%0d ready=%b, required tx=%0d ready=1", it, log_q.size() - b, cfg_ready, 4 * N);
      end
    end
  endtask

  task automatic test_drp_timeout();
    int dv[N] = '{5, 6, 7, 8};
    int base, c, t_err;
    bit got_done = 0;
    set_mem(1'b1, 16'h0);
    drop_rd = rd_total + 2;
    base = log_q.size();
    launch(pack(dv));
    t_err = -1; c = 0;
    while (!got_done && c < 1000) begin
      @(negedge clk); c++;
      if (err && t_err < 0) t_err = cyc;
      if (done) got_done = 1;
    end
    drop_rd = 0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_err: err_o=%b, required 1", err); end
    checks++;
    if (log_q.size() != base + 3) begin
      errors++;
      $display("FAIL to_tx: %0d transactions, required 3", log_q.size() - base);
    end else begin
      checks++;
      if (t_err - log_q[base + 2].cyc < 62 || t_err - log_q[base + 2].cyc > 68) begin
        errors++;
        $display("FAIL to_time: err_o %0d cycles after DEN, required 62..68", t_err - log_q[base + 2].cyc);
      end
    end
    checks++;
    if (!got_done) begin errors++; $display("FAIL to_done: no done_o pulse, required pulse"); end
    checks++;
    if ({mmcm_rst, cfg_ready} !== 2'b01) begin errors++; $display("FAIL to_idle: rst/ready=%b, required 01", {mmcm_rst, cfg_ready}); end
  endtask

  task automatic test_reset_midway();
    int dv[N] = '{10, 20, 30, 40};
    int c = 0;
    lock_hold_low = 1'b1;
    set_mem(1'b0, 16'h1234);
    launch(pack(dv));
    while (!(drp_if.drp_en && drp_if.drp_we) && c < 500) begin @(negedge clk); c++; end
    checks++;
    if (!(drp_if.drp_en && drp_if.drp_we)) begin errors++; $display("FAIL mid_wr: no DRP write seen, required one"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mmcm_rst, cfg_ready, done, err, locked, drp_if.drp_en, drp_if.drp_we} !== 7'b1000000) begin
      errors++;
      $display("FAIL mid_reset: rst/ready/done/err/locked/en/we=%b, required 1000000",
               {mmcm_rst, cfg_ready, done, err, locked, drp_if.drp_en, drp_if.drp_we});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    c = 0;
    while (!err && c < 70000) begin @(negedge clk); c++; end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL mid_lock_err: err_o=%b, required 1", err); end
    checks++;
    if (c < 65530 || c > 65545) begin errors++; $display("FAIL mid_lock_time: err_o after %0d cycles, required 65530..65545", c); end
    checks++;
    if ({mmcm_rst, locked, cfg_ready} !== 3'b001) begin
      errors++;
      $display("FAIL mid_idle: rst/locked/ready=%b, required 001", {mmcm_rst, locked, cfg_ready});
    end
    lock_hold_low = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_directed();
    test_d1_d7();
    test_div_zero();
    test_random();
    test_drp_timeout();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
